// File: rtl/fpmul_pkg.sv
// Shared types and constants for the floating-point multiplier scheduler.
package fpmul_pkg;

  localparam int FP_W        = 32;
  localparam int DEF_MUL_LAT = 5;

  // Tags are sized for the largest supported requester count so the types
  // stay fixed regardless of how many requesters an instance uses.
  localparam int MAX_REQ = 8;
  localparam int TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } slot_t;

  // Encode a one-hot grant vector into a requester index.
  function automatic tag_t onehot_to_tag(input logic [MAX_REQ-1:0] oh);
    tag_t t;
    t = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        t = t | tag_t'(i);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/fpmul_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after the
// pointer, and moves the pointer past the winner whenever a grant is made.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] win;
  logic [N-1:0]  pick;
  logic          found;
  logic [PW:0]   sum;
  logic [PW:0]   idx;

  // Scan requests starting at the pointer, wrapping modulo N.
  always_comb begin
    pick  = '0;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_reg} + (PW+1)'(i);
      idx = (sum >= (PW+1)'(N)) ? (sum - (PW+1)'(N)) : sum;
      if (!found && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        win                  = idx[PW-1:0];
        pick[idx[PW-1:0]]    = 1'b1;
      end
    end
  end

  assign gnt = en ? pick : '0;

  // Pointer advances to winner+1 only when a grant is actually issued.
  always_comb begin
    ptr_next = ptr_reg;
    if (en && found) begin
      ptr_next = (win == PW'(N-1)) ? '0 : (win + PW'(1));
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/fpmul_sched.sv
// Shares one pipelined FP multiplier among several requesters: arbitrates,
// registers the winning operands, tracks ownership through a tag pipeline
// matched to the multiplier latency and routes each result back.
// The multiplier's active-low reset is driven from ~reset by the parent.
module fpmul_sched
  import fpmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    hold,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  input  logic [FP_W-1:0]         mul_c,
  input  logic                    mul_overflow,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]         rsp_c,
  output logic                    rsp_overflow,
  output logic [2:0]              inflight,
  output logic                    busy
);

  logic               run_reg;
  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic               handshake;
  tag_t               win_tag;
  logic [FP_W-1:0]    sel_a;
  logic [FP_W-1:0]    sel_b;

  logic               iss_v_reg;
  tag_t               iss_tag_reg;
  logic [FP_W-1:0]    mul_a_reg;
  logic [FP_W-1:0]    mul_b_reg;
  slot_t              pipe_reg [MUL_LAT];
  slot_t              last_slot;
  logic [2:0]         inflight_reg;

  // Grants start one cycle after reset is released, so the asynchronous
  // deassertion never races a grant in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  assign arb_en = run_reg & ~hold;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (arb_en),
    .gnt   (gnt)
  );

  // gnt is only ever set on a valid requester, so any grant is a handshake.
  assign req_ready = gnt;
  assign handshake = |gnt;
  assign win_tag   = onehot_to_tag(MAX_REQ'(gnt));

  // Select the winning requester's operand pair.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*FP_W +: FP_W];
        sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  // Issue stage: operands hold when idle, only the valid bit drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_v_reg   <= 1'b0;
      iss_tag_reg <= '0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
    end else begin
      iss_v_reg <= handshake;
      if (handshake) begin
        iss_tag_reg <= win_tag;
        mul_a_reg   <= sel_a;
        mul_b_reg   <= sel_b;
      end
    end
  end

  assign mul_a = mul_a_reg;
  assign mul_b = mul_b_reg;

  // Tag pipeline shadowing the multiplier; the last stage lines up with mul_c.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        pipe_reg[s] <= '0;
      end
    end else begin
      pipe_reg[0] <= '{valid: iss_v_reg, tag: iss_tag_reg};
      for (int s = 1; s < MUL_LAT; s++) begin
        pipe_reg[s] <= pipe_reg[s-1];
      end
    end
  end

  assign last_slot = pipe_reg[MUL_LAT-1];

  // Route the result strobe to the owner of the returning slot.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = last_slot.valid & (last_slot.tag == tag_t'(gi));
    end
  endgenerate

  // Result and flag are forwarded untouched, including overflow patterns.
  assign rsp_c        = mul_c;
  assign rsp_overflow = mul_overflow;

  // Outstanding-operation counter; bounded by MUL_LAT+1 by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg <= '0;
    end else begin
      case ({handshake, last_slot.valid})
        2'b10:   inflight_reg <= inflight_reg + 3'd1;
        2'b01:   inflight_reg <= inflight_reg - 3'd1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  assign inflight = inflight_reg;
  assign busy     = (inflight_reg != 3'd0);

endmodule
